// File: rtl/broadcast_stream_unit_pkg.sv
// Shared types and helpers for the broadcast stream unit.
package broadcast_stream_unit_pkg;

    localparam int unsigned ELEM_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCfg    = 2'd1,
        StFill   = 2'd2,
        StStream = 2'd3
    } state_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/broadcast_stream_unit_lane_index.sv
// Wrap-around lane index generator: builds lane_off[j] = j mod N and step = LANES mod N
// during CFG by increment/compare-subtract, then yields start+lane_off[j] mod N per lane.
module bcast_lane_index #(
    parameter int unsigned LANES = 8,
    parameter int unsigned AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     restart,
    input  logic                     cfg_en,
    input  logic                     advance,
    input  logic [AW-1:0]            n,
    output logic                     cfg_last,
    output logic [LANES-1:0][AW-1:0] idx
);

    localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [CW-1:0] cfg_cnt;
    logic [AW-1:0] run;
    logic [AW-1:0] start;
    logic [AW-1:0] step;
    logic [AW-1:0] lane_off [LANES];

    logic [AW:0]   run_inc;
    logic [AW-1:0] run_wrap;
    logic [AW:0]   start_sum;
    logic [AW-1:0] start_wrap;
    logic [AW:0]   off_sum [LANES];

    always_comb begin
        run_inc    = {1'b0, run} + (AW+1)'(1);
        run_wrap   = (run_inc >= {1'b0, n}) ? AW'(run_inc - {1'b0, n}) : run_inc[AW-1:0];
        start_sum  = {1'b0, start} + {1'b0, step};
        start_wrap = (start_sum >= {1'b0, n}) ? AW'(start_sum - {1'b0, n})
                                              : start_sum[AW-1:0];
        cfg_last   = (cfg_cnt == CW'(LANES - 1));
        for (int j = 0; j < LANES; j++) begin
            off_sum[j] = {1'b0, start} + {1'b0, lane_off[j]};
            idx[j]     = (off_sum[j] >= {1'b0, n}) ? AW'(off_sum[j] - {1'b0, n})
                                                   : off_sum[j][AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_cnt <= '0;
            run     <= '0;
            start   <= '0;
            step    <= '0;
            for (int j = 0; j < LANES; j++) begin
                lane_off[j] <= '0;
            end
        end else if (clear || restart) begin
            cfg_cnt <= '0;
            run     <= '0;
            start   <= '0;
        end else if (cfg_en) begin
            lane_off[cfg_cnt] <= run;
            run               <= run_wrap;
            cfg_cnt           <= cfg_cnt + CW'(1);
            // After LANES increments the running value is exactly LANES mod N.
            if (cfg_last) begin
                step <= run_wrap;
            end
        end else if (advance) begin
            start <= start_wrap;
        end
    end

endmodule

// File: rtl/broadcast_stream_unit.sv
// Operand broadcast cache: config, fill from SRAM, then stream LANES-wide wrap-around beats.
module broadcast_stream_unit
    import broadcast_stream_unit_pkg::*;
#(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ELEM_W = ELEM_W_DEF,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned AW     = addr_width(DEPTH),
    parameter int unsigned CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [AW-1:0]           cfg_n_i,
    input  logic [CNT_W-1:0]        cfg_beats_i,
    input  logic                    cfg_splat_i,
    input  logic [AW-1:0]           cfg_splat_idx_i,
    output logic                    cfg_err_o,
    input  logic                    fill_valid_i,
    output logic                    fill_ready_o,
    input  logic [AW-1:0]           fill_addr_i,
    input  logic [LANES*ELEM_W-1:0] fill_data_i,
    input  logic                    fill_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*ELEM_W-1:0] out_data_o,
    output logic                    done_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned DW = LANES * ELEM_W;

    state_t               state;
    logic [AW-1:0]        n_reg;
    logic [CNT_W-1:0]     beats_left;
    logic                 splat;
    logic [AW-1:0]        splat_idx;

    logic [ELEM_W-1:0]    cache [DEPTH];

    logic                 cfg_bad;
    logic                 cfg_fire;
    logic                 fill_fire;
    logic                 accept;
    logic                 load;
    logic [LANES-1:0][AW-1:0] lane_idx;
    logic                 lane_cfg_last;
    logic [AW:0]          waddr [LANES];
    logic [AW-1:0]        raddr [LANES];
    logic [DW-1:0]        rd_data;
    logic                 unused_raddr;

    assign cfg_ready_o  = (state == StIdle);
    assign fill_ready_o = (state == StFill);

    always_comb begin
        cfg_bad   = (cfg_n_i == '0) || (cfg_n_i > AW'(DEPTH)) ||
                    (cfg_splat_i && (cfg_splat_idx_i >= cfg_n_i));
        cfg_fire  = (state == StIdle) && cfg_valid_i && !init_i;
        fill_fire = (state == StFill) && fill_valid_i && !init_i;
        accept    = (state == StStream) && out_valid_o && out_ready_i && !init_i;
        // The final beat's acceptance ends the stream, so it never triggers a new load.
        load      = (state == StStream) && !init_i &&
                    ((!out_valid_o && (beats_left != '0)) ||
                     (out_valid_o && out_ready_i && (beats_left > CNT_W'(1))));
    end

    bcast_lane_index #(
        .LANES (LANES),
        .AW    (AW)
    ) u_lane_index (
        .clk      (clk),
        .rst      (rst),
        .clear    (init_i),
        .restart  (cfg_fire && !cfg_bad),
        .cfg_en   ((state == StCfg) && !init_i),
        .advance  (load),
        .n        (n_reg),
        .cfg_last (lane_cfg_last),
        .idx      (lane_idx)
    );

    always_comb begin
        unused_raddr = 1'b0;
        rd_data      = '0;
        for (int j = 0; j < LANES; j++) begin
            waddr[j] = {1'b0, fill_addr_i} + (AW+1)'(j);
            raddr[j] = splat ? splat_idx : lane_idx[j];
            rd_data[j*ELEM_W +: ELEM_W] = cache[raddr[j][IW-1:0]];
            unused_raddr = unused_raddr ^ (^raddr[j][AW-1:IW]);
        end
    end

    // Storage only; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            for (int j = 0; j < LANES; j++) begin
                if (waddr[j] < {1'b0, n_reg}) begin
                    cache[waddr[j][IW-1:0]] <= fill_data_i[j*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            n_reg       <= '0;
            beats_left  <= '0;
            splat       <= 1'b0;
            splat_idx   <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            done_o      <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            cfg_err_o <= 1'b0;
            if (init_i) begin
                state       <= StIdle;
                out_valid_o <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (cfg_valid_i) begin
                            if (cfg_bad) begin
                                cfg_err_o <= 1'b1;
                            end else begin
                                n_reg      <= cfg_n_i;
                                beats_left <= cfg_beats_i;
                                splat      <= cfg_splat_i;
                                splat_idx  <= cfg_splat_idx_i;
                                state      <= StCfg;
                            end
                        end
                    end
                    StCfg: begin
                        if (lane_cfg_last) begin
                            state <= StFill;
                        end
                    end
                    StFill: begin
                        if (fill_valid_i && fill_last_i) begin
                            if (beats_left == '0) begin
                                done_o <= 1'b1;
                                state  <= StIdle;
                            end else begin
                                state <= StStream;
                            end
                        end
                    end
                    StStream: begin
                        if (accept) begin
                            beats_left <= beats_left - CNT_W'(1);
                            if (beats_left == CNT_W'(1)) begin
                                out_valid_o <= 1'b0;
                                done_o      <= 1'b1;
                                state       <= StIdle;
                            end
                        end
                        if (load) begin
                            out_valid_o <= 1'b1;
                            out_data_o  <= rd_data;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_broadcast_stream_unit.sv
// Scenario bench for broadcast_stream_unit with a modulo-arithmetic reference and beat scoreboard.
module tb_broadcast_stream_unit;

    localparam int unsigned LANES  = 8;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned AW     = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DW     = LANES * ELEM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              init;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [AW-1:0]     cfg_n;
    logic [CNT_W-1:0]  cfg_beats;
    logic              cfg_splat;
    logic [AW-1:0]     cfg_splat_idx;
    logic              cfg_err;
    logic              fill_valid;
    logic              fill_ready;
    logic [AW-1:0]     fill_addr;
    logic [DW-1:0]     fill_data;
    logic              fill_last;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              done;

    int errors = 0;
    int checks = 0;
    logic [ELEM_W-1:0] model_mem [DEPTH];
    logic [DW-1:0]     exp_q [$];

    always #5 clk = ~clk;

    broadcast_stream_unit #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .init_i          (init),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_n_i         (cfg_n),
        .cfg_beats_i     (cfg_beats),
        .cfg_splat_i     (cfg_splat),
        .cfg_splat_idx_i (cfg_splat_idx),
        .cfg_err_o       (cfg_err),
        .fill_valid_i    (fill_valid),
        .fill_ready_o    (fill_ready),
        .fill_addr_i     (fill_addr),
        .fill_data_i     (fill_data),
        .fill_last_i     (fill_last),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .done_o          (done)
    );

    task automatic test_reset();
        rst = 1'b1; init = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_beats = '0;
        cfg_splat = 1'b0; cfg_splat_idx = '0; fill_valid = 1'b0; fill_addr = '0;
        fill_data = '0; fill_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cfg_ready, fill_ready, out_valid, done, cfg_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset flags: got %b want 10000",
                     {cfg_ready, fill_ready, out_valid, done, cfg_err});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset data: got %h want 0", out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Configure, fill 0..n-1 with base+addr, and optionally queue the expected beats.
    task automatic setup_stream(input string name, input int n, input int beats, input bit splat,
                                input int sidx, input int base, input bit push);
        int k;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        int st;
        cfg_valid = 1'b1; cfg_n = AW'(n); cfg_beats = CNT_W'(beats);
        cfg_splat = splat; cfg_splat_idx = AW'(sidx);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s cfg accept: got err=%b ready=%b want 0 0", name, cfg_err, cfg_ready);
        end
        k = 0;
        while (fill_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k != LANES) begin
            errors++;
            $display("FAIL %s cfg length: got %0d cycles want %0d", name, k, LANES);
        end
        for (int a = 0; a < n; a += LANES) begin
            for (int j = 0; j < LANES; j++) begin
                d[j*ELEM_W +: ELEM_W] = ELEM_W'(base + a + j);
                if (a + j < n) model_mem[a + j] = ELEM_W'(base + a + j);
            end
            fill_valid = 1'b1; fill_addr = AW'(a); fill_data = d;
            fill_last = (a + LANES >= n);
            @(posedge clk); #1;
        end
        fill_valid = 1'b0; fill_last = 1'b0;
        if (push) begin
            for (int b = 0; b < beats; b++) begin
                st = (b * LANES) % n;
                for (int j = 0; j < LANES; j++) begin
                    e[j*ELEM_W +: ELEM_W] = splat ? model_mem[sidx] : model_mem[(st + j) % n];
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain_stream(input string name, input int beats, input bit toggle,
                                output int cycles);
        int got = 0;
        int cyc = 0;
        int dones = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev = '0;
        logic [DW-1:0] e;
        while (got < beats && cyc < 400) begin
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev) begin
                    errors++;
                    $display("FAIL %s stall hold: got v=%b %h want v=1 %h",
                             name, out_valid, out_data, prev);
                end
            end
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1 && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL %s beat %0d: got %h want %h", name, got, out_data, e);
                end
                got++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev = out_data;
            @(posedge clk); #1;
            cyc++;
        end
        cycles = cyc;
        out_ready = 1'b0;
        checks++;
        if (got != beats) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, got, beats);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || dones != 0) begin
            errors++;
            $display("FAIL %s end: got done=%b valid=%b early=%0d want 1 0 0",
                     name, done, out_valid, dones);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: got done=%b ready=%b want 0 1", name, done, cfg_ready);
        end
    endtask

    task automatic test_full_vector();
        int cyc;
        setup_stream("n8", 8, 4, 1'b0, 0, 0, 1'b1);
        drain_stream("n8", 4, 1'b0, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL n8 throughput: got %0d cycles want 5", cyc);
        end
    endtask

    task automatic test_wrap_n5();
        int cyc;
        setup_stream("n5", 5, 3, 1'b0, 0, 10, 1'b1);
        drain_stream("n5", 3, 1'b0, cyc);
    endtask

    task automatic test_splat_stall();
        int cyc;
        setup_stream("splat", 3, 5, 1'b1, 2, 20, 1'b1);
        drain_stream("splat", 5, 1'b1, cyc);
    endtask

    task automatic test_partial_fill();
        int cyc;
        setup_stream("n12", 12, 4, 1'b0, 0, 0, 1'b1);
        drain_stream("n12", 4, 1'b0, cyc);
    endtask

    task automatic test_single_element();
        int cyc;
        setup_stream("n1", 1, 2, 1'b0, 0, 77, 1'b1);
        drain_stream("n1", 2, 1'b1, cyc);
    endtask

    task automatic test_cfg_reject(input string name, input int n, input bit splat, input int sidx);
        cfg_valid = 1'b1; cfg_n = AW'(n); cfg_beats = 32'd4;
        cfg_splat = splat; cfg_splat_idx = AW'(sidx);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse: got err=%b ready=%b want 1 1", name, cfg_err, cfg_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b0 || fill_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after: got err=%b fill=%b ready=%b want 0 0 1",
                     name, cfg_err, fill_ready, cfg_ready);
        end
    endtask

    task automatic test_zero_beats();
        setup_stream("zero", 4, 0, 1'b0, 0, 40, 1'b0);
        checks++;
        if (done !== 1'b1 || cfg_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero done: got done=%b ready=%b valid=%b want 1 1 0",
                     done, cfg_ready, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero pulse: got done=%b want 0", done);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b want 1", name, out_valid);
        end
    endtask

    task automatic test_init_abort();
        setup_stream("init", 8, 10, 1'b0, 0, 50, 1'b0);
        wait_valid("init");
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL init abort: got valid=%b done=%b ready=%b want 0 0 1",
                     out_valid, done, cfg_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || fill_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL init settle: got done=%b fill=%b valid=%b want 0 0 0",
                     done, fill_ready, out_valid);
        end
    endtask

    task automatic test_async_reset();
        setup_stream("arst", 8, 10, 1'b0, 0, 60, 1'b0);
        wait_valid("arst");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || cfg_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL arst: got valid=%b ready=%b data=%h want 0 1 0",
                     out_valid, cfg_ready, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst settle: got done=%b valid=%b want 0 0", done, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_wrap_n5();
        test_splat_stall();
        test_cfg_reject("rej_n0", 0, 1'b0, 0);
        test_cfg_reject("rej_big", DEPTH + 1, 1'b0, 0);
        test_cfg_reject("rej_idx", 3, 1'b1, 3);
        test_partial_fill();
        test_single_element();
        test_zero_beats();
        test_init_abort();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard left: got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
